// File: rtl/if_id_skid_pkg.sv
// Shared constants for the fetch/decode boundary: reset polarity, default bus
// widths, the canonical NOP, and a saturating increment for the bubble counter.
package if_id_skid_pkg;

    localparam logic RstEnable   = 1'b1;
    localparam int   InstBus     = 32;
    localparam int   InstAddrBus = 32;
    localparam int   BubbleW     = 32;

    localparam logic [InstAddrBus-1:0] ZeroInstAddr = '0;
    localparam logic [InstBus-1:0]     NopInst      = 32'h0000_0013;

    function automatic logic [BubbleW-1:0] sat_inc(input logic [BubbleW-1:0] v);
        return (&v) ? v : v + BubbleW'(1);
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic one-entry skid pipeline register. ready_o comes straight from a flop,
// so downstream stalls never reach upstream combinationally.
module pipe_skid_buf
    import if_id_skid_pkg::*;
#(
    parameter int             W     = 1,
    parameter logic [W-1:0]   EMPTY = '0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [W-1:0] data_o
);

    logic         r_out_v;
    logic         r_skid_v;
    logic [W-1:0] r_out_d;
    logic [W-1:0] r_skid_d;

    logic w_out_free;
    logic w_accept;

    assign w_out_free = !r_out_v || ready_i;
    assign w_accept   = valid_i && !r_skid_v;

    always_ff @(posedge clk_i) begin
        if (rst_i == RstEnable || clr_i) begin
            r_out_v  <= 1'b0;
            r_skid_v <= 1'b0;
            r_out_d  <= EMPTY;
        end else if (w_out_free) begin
            // Drain the skid first; it is always older than anything on the input.
            if (r_skid_v) begin
                r_out_v  <= 1'b1;
                r_out_d  <= r_skid_d;
                r_skid_v <= 1'b0;
            end else begin
                r_out_v <= valid_i;
                r_out_d <= valid_i ? data_i : EMPTY;
            end
        end else if (w_accept) begin
            r_skid_v <= 1'b1;
        end
    end

    // Skid payload is only meaningful while r_skid_v is set, so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (!w_out_free && w_accept)
            r_skid_d <= data_i;
    end

    assign valid_o = r_out_v;
    assign ready_o = !r_skid_v;
    assign data_o  = r_out_d;

endmodule

// File: rtl/if_id_skid.sv
// IF/ID pipeline register with skid buffer, flush-to-bubble, NOP on empty
// output, and a saturating count of bubble cycles seen by decode.
module if_id_skid
    import if_id_skid_pkg::*;
#(
    parameter int                INST_W   = InstBus,
    parameter int                ADDR_W   = InstAddrBus,
    parameter int                SB_W     = 1,
    parameter logic [INST_W-1:0] NOP_INST = INST_W'(NopInst)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    input  logic                valid_i,
    output logic                ready_o,
    input  logic [INST_W-1:0]   inst_i,
    input  logic [ADDR_W-1:0]   inst_addr_i,
    input  logic [SB_W-1:0]     sb_i,
    output logic                valid_o,
    input  logic                ready_i,
    output logic [INST_W-1:0]   inst_o,
    output logic [ADDR_W-1:0]   inst_addr_o,
    output logic [SB_W-1:0]     sb_o,
    output logic [BubbleW-1:0]  bubble_cnt_o
);

    localparam int           W     = INST_W + ADDR_W + SB_W;
    localparam logic [W-1:0] EMPTY = {NOP_INST, ADDR_W'(ZeroInstAddr), {SB_W{1'b0}}};

    logic [W-1:0]       w_in;
    logic [W-1:0]       w_out;
    logic               w_valid;
    logic [BubbleW-1:0] r_bubble_cnt;

    assign w_in = {inst_i, inst_addr_i, sb_i};

    pipe_skid_buf #(
        .W     (W),
        .EMPTY (EMPTY)
    ) u_skid (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (flush_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (w_in),
        .valid_o (w_valid),
        .ready_i (ready_i),
        .data_o  (w_out)
    );

    assign valid_o                       = w_valid;
    assign {inst_o, inst_addr_o, sb_o}   = w_out;

    // Counts edges whose pre-edge output was empty, flush edges included.
    always_ff @(posedge clk_i) begin
        if (rst_i == RstEnable)
            r_bubble_cnt <= '0;
        else if (!w_valid)
            r_bubble_cnt <= sat_inc(r_bubble_cnt);
    end

    assign bubble_cnt_o = r_bubble_cnt;

endmodule

// File: tb/tb_if_id_skid.sv
// Bench for if_id_skid: directed vector table, counter saturation, and a
// randomized run against a two-deep in-order queue model.
module tb_if_id_skid;

    logic        clk_i = 1'b0;
    logic        rst_i, flush_i, valid_i, ready_i;
    logic        ready_o, valid_o;
    logic [31:0] inst_i, inst_addr_i, inst_o, inst_addr_o, bubble_cnt_o;
    logic [0:0]  sb_i, sb_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_i = ~clk_i;

    if_id_skid dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .flush_i      (flush_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .inst_i       (inst_i),
        .inst_addr_i  (inst_addr_i),
        .sb_i         (sb_i),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .inst_o       (inst_o),
        .inst_addr_o  (inst_addr_o),
        .sb_o         (sb_o),
        .bubble_cnt_o (bubble_cnt_o)
    );

    typedef struct {
        logic        rst, flush, vin, rdy;
        logic [31:0] a;
        logic        ev, er;
        logic [31:0] ea, eb;
    } vec_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] addr;
        logic        sb;
    } ent_t;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] KEY = 32'hA5A5_0000;

    vec_t tv[$];

    function automatic vec_t mk(logic rst, logic flush, logic vin, logic rdy, logic [31:0] a,
                                logic ev, logic er, logic [31:0] ea, logic [31:0] eb);
        vec_t v;
        v.rst = rst; v.flush = flush; v.vin = vin; v.rdy = rdy; v.a = a;
        v.ev = ev; v.er = er; v.ea = ea; v.eb = eb;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic r, input logic f, input logic v, input logic rd,
                         input logic [31:0] inst, input logic [31:0] a, input logic sb);
        rst_i = r; flush_i = f; valid_i = v; ready_i = rd;
        inst_i = inst; inst_addr_i = a; sb_i = sb;
    endtask

    initial begin
        ent_t        q[$];
        ent_t        cur, head;
        logic [31:0] bub_m;
        logic [31:0] seq;
        logic [64:0] prev_d;
        logic        hold_exp;
        int          pre;
        logic        f, vin, rd;

        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

        // rst flush vin rdy addr | exp valid ready addr bubbles
        tv.push_back(mk(1,0,1,0,32'h000, 0,1,32'h000,0));
        tv.push_back(mk(1,0,1,0,32'h000, 0,1,32'h000,0));
        for (int i = 1; i <= 5; i++)
            tv.push_back(mk(0,0,0,1,32'h0, 0,1,32'h0,i));
        for (int k = 0; k < 8; k++)
            tv.push_back(mk(0,0,1,1,32'h100 + 4*k, 1,1,32'h100 + 4*k,6));
        tv.push_back(mk(0,0,0,1,32'h000, 0,1,32'h000,6));
        // stall: 0x200 on output, 0x204 into skid, ready_i low three cycles
        tv.push_back(mk(0,0,1,1,32'h200, 1,1,32'h200,7));
        tv.push_back(mk(0,0,1,0,32'h204, 1,0,32'h200,7));
        tv.push_back(mk(0,0,1,0,32'h208, 1,0,32'h200,7));
        tv.push_back(mk(0,0,1,0,32'h208, 1,0,32'h200,7));
        tv.push_back(mk(0,0,1,1,32'h208, 1,1,32'h204,7));
        tv.push_back(mk(0,0,0,1,32'h000, 0,1,32'h000,7));
        // flush with both entries full and 0x308 on the input
        tv.push_back(mk(0,0,1,1,32'h300, 1,1,32'h300,8));
        tv.push_back(mk(0,0,1,0,32'h304, 1,0,32'h300,8));
        tv.push_back(mk(0,1,1,1,32'h308, 0,1,32'h000,8));
        tv.push_back(mk(0,0,0,1,32'h000, 0,1,32'h000,9));
        tv.push_back(mk(1,0,0,1,32'h000, 0,1,32'h000,0));

        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i].rst, tv[i].flush, tv[i].vin, tv[i].rdy,
                  tv[i].rst ? 32'hDEAD_BEEF : (tv[i].a ^ KEY), tv[i].a, tv[i].a[2]);
            tick();
            chk($sformatf("vec%0d valid", i), 128'(valid_o), 128'(tv[i].ev));
            chk($sformatf("vec%0d ready", i), 128'(ready_o), 128'(tv[i].er));
            chk($sformatf("vec%0d inst", i), 128'(inst_o), 128'(tv[i].ev ? (tv[i].ea ^ KEY) : NOP));
            chk($sformatf("vec%0d addr", i), 128'(inst_addr_o), 128'(tv[i].ea));
            chk($sformatf("vec%0d sb", i), 128'(sb_o), 128'(tv[i].ea[2]));
            chk($sformatf("vec%0d bubbles", i), 128'(bubble_cnt_o), 128'(tv[i].eb));
        end

        // Saturation: preload the counter at its ceiling and idle.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
        force dut.r_bubble_cnt = 32'hFFFF_FFFF;
        tick();
        release dut.r_bubble_cnt;
        for (int i = 0; i < 3; i++) tick();
        chk("bubble saturate", 128'(bubble_cnt_o), 128'(32'hFFFF_FFFF));

        // Randomized run against an in-order queue of at most two entries.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        q.delete();
        bub_m = 0;
        seq   = 1;
        for (int c = 0; c < 10000; c++) begin
            f   = ($urandom_range(63) == 0);
            vin = ($urandom_range(9) < 7);
            rd  = ($urandom_range(9) < 6);
            cur.inst = $urandom;
            cur.addr = seq << 2;
            cur.sb   = 1'($urandom_range(1));
            drive(1'b0, f, vin, rd, cur.inst, cur.addr, cur.sb);

            hold_exp = valid_o && !rd && !f;
            prev_d   = {inst_o, inst_addr_o, sb_o};

            pre = q.size();
            if (pre == 0 && bub_m != 32'hFFFF_FFFF) bub_m++;
            if (f) q.delete();
            else begin
                if (pre > 0 && rd) void'(q.pop_front());
                if (vin && pre < 2) begin
                    q.push_back(cur);
                    seq++;
                end
            end

            tick();
            if (q.size() > 0) head = q[0];
            else begin
                head.inst = NOP; head.addr = 32'h0; head.sb = 1'b0;
            end
            chk($sformatf("rand c%0d out", c),
                128'({valid_o, ready_o, inst_o, inst_addr_o, sb_o}),
                128'({q.size() > 0, q.size() < 2, head.inst, head.addr, head.sb}));
            if (hold_exp)
                chk($sformatf("rand c%0d hold", c),
                    128'({inst_o, inst_addr_o, sb_o}), 128'(prev_d));
        end
        chk("rand bubbles", 128'(bubble_cnt_o), 128'(bub_m));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
